// File: rtl/tone_detector.sv
// Square-wave tone detector: measures half-periods of SPK_IN and reports the matching note code.
// Define TONE_DEGLITCH_EN to add a 4-cycle glitch filter after the synchronizer (+3 clocks latency).
module tone_detector #(
  parameter int unsigned TOL     = 64,
  parameter int unsigned STABLE  = 3,
  parameter int unsigned TIMEOUT = 40000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        SPK_IN,
  output logic [3:0]  NOTE,
  output logic        NOTE_VALID,
  output logic        NOTE_STROBE,
  output logic [15:0] PERIOD
);

  localparam logic [15:0]        TimeoutCnt = 16'(TIMEOUT);
  localparam logic [2:0]         StableCnt  = 3'(STABLE);
  localparam logic signed [16:0] TolS       = $signed(17'(TOL));

  function automatic logic [15:0] nominal(input logic [3:0] code);
    case (code)
      4'd1:    nominal = 16'd32121;
      4'd2:    nominal = 16'd28601;
      4'd3:    nominal = 16'd26841;
      4'd4:    nominal = 16'd23761;
      4'd5:    nominal = 16'd21121;
      4'd6:    nominal = 16'd20241;
      4'd7:    nominal = 16'd18041;
      4'd8:    nominal = 16'd16061;
      4'd9:    nominal = 16'd14301;
      default: nominal = 16'd0;
    endcase
  endfunction

  // Table entries are >= 880 clocks apart, so at most one code can fall inside the window.
  function automatic logic [3:0] match_code(input logic [15:0] h);
    logic signed [16:0] diff;
    match_code = 4'd0;
    for (int c = 1; c <= 9; c++) begin
      diff = $signed({1'b0, h}) - $signed({1'b0, nominal(4'(c))});
      if (diff <= TolS && diff >= -TolS) match_code = 4'(c);
    end
  endfunction

  logic        sync1_q, sync2_q, lvl_q;
  logic        edge_seen, timeout;
  logic [15:0] cnt_q, cnt_d;
  logic        armed_q, armed_d;
  logic        meas_q, meas_d;
  logic [3:0]  m_q, m_d;
  logic [15:0] period_q, period_d;
  logic [2:0]  stab_q, stab_d;
  logic [3:0]  prev_m_q, prev_m_d;
  logic        upd_q;
  logic [3:0]  note_q, note_d;
  logic        valid_q, valid_d;
  logic        strobe_q, strobe_d;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= SPK_IN;
      sync2_q <= sync1_q;
    end
  end

`ifdef TONE_DEGLITCH_EN
  logic [1:0] run_q;

  // Accept a new level only once it has differed from the accepted level for 4 cycles.
  assign edge_seen = (sync2_q != lvl_q) && (run_q == 2'd3);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      lvl_q <= 1'b0;
      run_q <= 2'd0;
    end else if (sync2_q != lvl_q) begin
      if (run_q == 2'd3) begin
        lvl_q <= sync2_q;
        run_q <= 2'd0;
      end else begin
        run_q <= run_q + 2'd1;
      end
    end else begin
      run_q <= 2'd0;
    end
  end
`else
  assign edge_seen = (sync2_q != lvl_q);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) lvl_q <= 1'b0;
    else        lvl_q <= sync2_q;
  end
`endif

  // An edge in the timeout cycle wins over the timeout.
  assign timeout = (cnt_q == TimeoutCnt) && !edge_seen;

  // Capture stage: half-period counter, arming and measurement.
  always_comb begin
    cnt_d    = cnt_q;
    armed_d  = armed_q;
    meas_d   = 1'b0;
    m_d      = m_q;
    period_d = period_q;
    if (edge_seen) begin
      cnt_d   = 16'd1;
      armed_d = 1'b1;
      if (armed_q && (cnt_q < TimeoutCnt)) begin
        meas_d   = 1'b1;
        m_d      = match_code(cnt_q);
        period_d = cnt_q;
      end
    end else begin
      if (cnt_q != 16'hffff) cnt_d = cnt_q + 16'd1;
      if (timeout) armed_d = 1'b0;
    end
  end

  // Stability stage.
  always_comb begin
    stab_d   = stab_q;
    prev_m_d = prev_m_q;
    if (timeout) begin
      stab_d   = 3'd0;
      prev_m_d = 4'd0;
    end else if (meas_q) begin
      prev_m_d = m_q;
      if (m_q == 4'd0)           stab_d = 3'd0;
      else if (m_q != prev_m_q)  stab_d = 3'd1;
      else if (stab_q != StableCnt) stab_d = stab_q + 3'd1;
    end
  end

  // Output stage.
  always_comb begin
    note_d   = note_q;
    valid_d  = valid_q;
    strobe_d = 1'b0;
    if (timeout) begin
      note_d   = 4'd0;
      valid_d  = 1'b0;
      strobe_d = valid_q;
    end else if (upd_q && (stab_q == StableCnt) && (prev_m_q != note_q)) begin
      note_d   = prev_m_q;
      valid_d  = 1'b1;
      strobe_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cnt_q    <= 16'd0;
      armed_q  <= 1'b0;
      meas_q   <= 1'b0;
      m_q      <= 4'd0;
      period_q <= 16'd0;
      stab_q   <= 3'd0;
      prev_m_q <= 4'd0;
      upd_q    <= 1'b0;
      note_q   <= 4'd0;
      valid_q  <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      armed_q  <= armed_d;
      meas_q   <= meas_d;
      m_q      <= m_d;
      period_q <= period_d;
      stab_q   <= stab_d;
      prev_m_q <= prev_m_d;
      upd_q    <= meas_q && !timeout;
      note_q   <= note_d;
      valid_q  <= valid_d;
      strobe_q <= strobe_d;
    end
  end

  assign NOTE        = note_q;
  assign NOTE_VALID  = valid_q;
  assign NOTE_STROBE = strobe_q;
  assign PERIOD      = period_q;

endmodule

// File: tb/tb_tone_detector.sv
// Self-checking bench for tone_detector: three instances with different parameters run
// directed half-period sequences in parallel on one clock.
module tb_tone_detector;

`ifdef TONE_DEGLITCH_EN
  localparam int unsigned LatPos = 8;
  localparam bit          Gl     = 1'b1;
`else
  localparam int unsigned LatPos = 5;
  localparam bit          Gl     = 1'b0;
`endif

  typedef struct {
    bit          toggle;
    int unsigned hp;
    bit          glitch;
    int unsigned n_strobe;
    int unsigned pos;
    logic [3:0]  note;
    logic        valid;
    logic [15:0] period;
  } vec_t;

  logic             CLK = 1'b0;
  logic [2:0]       rstn = '1;
  logic [2:0]       spk = '0;
  logic [2:0][3:0]  note;
  logic [2:0]       valid;
  logic [2:0]       strobe;
  logic [2:0][15:0] period;

  int n_tests = 0;
  int n_fail  = 0;

  vec_t tab0 [5];
  vec_t tab1 [6];
  vec_t tab2 [5];

  always #20 CLK = ~CLK;

  tone_detector #(.TOL(64), .STABLE(2), .TIMEOUT(33000)) u0 (
    .CLK(CLK), .RESET(rstn[0]), .SPK_IN(spk[0]), .NOTE(note[0]), .NOTE_VALID(valid[0]),
    .NOTE_STROBE(strobe[0]), .PERIOD(period[0])
  );
  tone_detector #(.TOL(64), .STABLE(1), .TIMEOUT(33000)) u1 (
    .CLK(CLK), .RESET(rstn[1]), .SPK_IN(spk[1]), .NOTE(note[1]), .NOTE_VALID(valid[1]),
    .NOTE_STROBE(strobe[1]), .PERIOD(period[1])
  );
  tone_detector #(.STABLE(1)) u2 (
    .CLK(CLK), .RESET(rstn[2]), .SPK_IN(spk[2]), .NOTE(note[2]), .NOTE_VALID(valid[2]),
    .NOTE_STROBE(strobe[2]), .PERIOD(period[2])
  );

  function automatic vec_t mk(bit tg, int unsigned hp, bit gl, int unsigned ns, int unsigned pos,
                              logic [3:0] nt, logic vl, logic [15:0] pr);
    vec_t v;
    v.toggle = tg; v.hp = hp; v.glitch = gl; v.n_strobe = ns; v.pos = pos;
    v.note = nt; v.valid = vl; v.period = pr;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outputs(input int d, input string tag, input logic [3:0] nt,
                               input logic vl, input logic st, input logic [15:0] pr);
    check($sformatf("u%0d.%s.note", d, tag), 32'(note[d]), 32'(nt));
    check($sformatf("u%0d.%s.valid", d, tag), 32'(valid[d]), 32'(vl));
    check($sformatf("u%0d.%s.strobe", d, tag), 32'(strobe[d]), 32'(st));
    check($sformatf("u%0d.%s.period", d, tag), 32'(period[d]), 32'(pr));
  endtask

  // Starts at a negedge, optionally toggles the input, then runs hp cycles ending on a negedge.
  task automatic run_step(input int d, input int k, input vec_t v);
    int unsigned n;
    int unsigned first;
    n = 0;
    first = 0;
    if (v.toggle) spk[d] = ~spk[d];
    for (int unsigned i = 1; i <= v.hp; i++) begin
      if (v.glitch && (i == 5000 || i == 5002)) spk[d] = ~spk[d];
      @(negedge CLK);
      if (strobe[d]) begin
        n++;
        if (first == 0) first = i;
      end
    end
    check($sformatf("u%0d.s%0d.strobe_count", d, k), n, v.n_strobe);
    if (v.pos != 0) check($sformatf("u%0d.s%0d.strobe_pos", d, k), first, v.pos);
    check($sformatf("u%0d.s%0d.note", d, k), 32'(note[d]), 32'(v.note));
    check($sformatf("u%0d.s%0d.valid", d, k), 32'(valid[d]), 32'(v.valid));
    check($sformatf("u%0d.s%0d.period", d, k), 32'(period[d]), 32'(v.period));
  endtask

  initial begin
    // u0: STABLE=2; note 9 then switch to note 5 (glitch inside a 21121 half when filtered).
    tab0[0] = mk(1, 14301, 0,  0, 0,      4'd0, 1'b0, 16'd0);
    tab0[1] = mk(1, 14301, 0,  0, 0,      4'd0, 1'b0, 16'd14301);
    tab0[2] = mk(1, 21121, 0,  1, LatPos, 4'd9, 1'b1, 16'd14301);
    tab0[3] = mk(1, 21121, Gl, 0, 0,      4'd9, 1'b1, 16'd21121);
    tab0[4] = mk(1, 20,    0,  1, LatPos, 4'd5, 1'b1, 16'd21121);
    // u1: STABLE=1; +65 rejected, +64 accepted, timeout, re-arm after timeout.
    tab1[0] = mk(1, 14366, 0, 0, 0,      4'd0, 1'b0, 16'd0);
    tab1[1] = mk(1, 14365, 0, 0, 0,      4'd0, 1'b0, 16'd14366);
    tab1[2] = mk(1, 100,   0, 1, LatPos, 4'd9, 1'b1, 16'd14365);
    tab1[3] = mk(0, 33100, 0, 1, 0,      4'd0, 1'b0, 16'd14365);
    tab1[4] = mk(1, 14301, 0, 0, 0,      4'd0, 1'b0, 16'd14365);
    tab1[5] = mk(1, 20,    0, 1, LatPos, 4'd9, 1'b1, 16'd14301);
    // u2: STABLE=1; -65 rejected, -64 accepted, reset mid-tone, then note 3.
    tab2[0] = mk(1, 14236, 0, 0, 0,      4'd0, 1'b0, 16'd0);
    tab2[1] = mk(1, 14237, 0, 0, 0,      4'd0, 1'b0, 16'd14236);
    tab2[2] = mk(1, 5000,  0, 1, LatPos, 4'd9, 1'b1, 16'd14237);
    tab2[3] = mk(1, 26841, 0, 0, 0,      4'd0, 1'b0, 16'd0);
    tab2[4] = mk(1, 20,    0, 1, LatPos, 4'd3, 1'b1, 16'd26841);

    #1 rstn = '0;
    #10;
    for (int d = 0; d < 3; d++) check_outputs(d, "reset", 4'd0, 1'b0, 1'b0, 16'd0);
    repeat (2) @(negedge CLK);
    rstn = '1;
    @(negedge CLK);

    fork
      begin
        for (int k = 0; k < 5; k++) run_step(0, k, tab0[k]);
      end
      begin
        for (int k = 0; k < 6; k++) run_step(1, k, tab1[k]);
      end
      begin
        for (int k = 0; k < 3; k++) run_step(2, k, tab2[k]);
        #7;
        rstn[2] = 1'b0;
        spk[2]  = 1'b0;
        #1;
        check_outputs(2, "midreset", 4'd0, 1'b0, 1'b0, 16'd0);
        repeat (2) @(negedge CLK);
        rstn[2] = 1'b1;
        for (int k = 3; k < 5; k++) run_step(2, k, tab2[k]);
      end
    join

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
